// File: rtl/bomb_pkg.sv
// Shared types and helpers for the bomb controller: slot states, grid geometry,
// cell encoding and the blast-cross mask.
package bomb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FUSE  = 2'd1,
    S_BLAST = 2'd2
  } slot_state_t;

  localparam int GRID_W     = 16;
  localparam int GRID_CELLS = GRID_W * GRID_W;

  // Cell index: x in [3:0], y in [7:4].
  typedef logic [7:0] cell_t;

  function automatic cell_t cell_idx(input int x, input int y);
    return cell_t'(y * GRID_W + x);
  endfunction

  // Bomb cell plus up to rng cells along each axis, clipped at the grid border.
  function automatic logic [GRID_CELLS-1:0] cross_mask(input cell_t c, input int rng);
    logic [GRID_CELLS-1:0] m;
    int x;
    int y;
    m = '0;
    x = int'(c[3:0]);
    y = int'(c[7:4]);
    m[c] = 1'b1;
    for (int d = 1; d <= 3; d++) begin
      if (d <= rng) begin
        if (x + d < GRID_W) m[cell_idx(x + d, y)] = 1'b1;
        if (x - d >= 0)     m[cell_idx(x - d, y)] = 1'b1;
        if (y + d < GRID_W) m[cell_idx(x, y + d)] = 1'b1;
        if (y - d >= 0)     m[cell_idx(x, y - d)] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: IDLE -> FUSE -> BLAST -> IDLE, timed by frame ticks, with an
// immediate jump to BLAST when another blast reaches the slot's cell.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int FUSE_TICKS  = 120,
  parameter int BLAST_TICKS = 30,
  parameter int CNT_W       = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_tick,
  input  logic        i_freeze,
  input  logic        i_load,
  input  cell_t       i_cell,
  input  logic        i_owner,
  input  logic        i_chain,
  output slot_state_t o_state,
  output cell_t       o_cell,
  output logic        o_owner
);

  slot_state_t      r_state;
  logic [CNT_W-1:0] r_count;
  cell_t            r_cell;
  logic             r_owner;

  slot_state_t      w_state_next;
  logic [CNT_W-1:0] w_count_next;
  cell_t            w_cell_next;
  logic             w_owner_next;
  logic             w_tick_ok;

  assign w_tick_ok = i_tick & ~i_freeze;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_cell  <= '0;
      r_owner <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_cell  <= w_cell_next;
      r_owner <= w_owner_next;
    end
  end

  // A freshly loaded slot ignores a coincident tick, so the fuse is always full length.
  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_cell_next  = r_cell;
    w_owner_next = r_owner;
    if (i_load) begin
      w_state_next = S_FUSE;
      w_count_next = CNT_W'(FUSE_TICKS);
      w_cell_next  = i_cell;
      w_owner_next = i_owner;
    end else begin
      case (r_state)
        S_FUSE: begin
          if (i_chain || (w_tick_ok && r_count == CNT_W'(1))) begin
            w_state_next = S_BLAST;
            w_count_next = CNT_W'(BLAST_TICKS);
          end else if (w_tick_ok) begin
            w_count_next = r_count - CNT_W'(1);
          end
        end
        S_BLAST: begin
          if (w_tick_ok && r_count == CNT_W'(1)) begin
            w_state_next = S_IDLE;
            w_count_next = '0;
          end else if (w_tick_ok) begin
            w_count_next = r_count - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_state = r_state;
  assign o_cell  = r_cell;
  assign o_owner = r_owner;

endmodule

// File: rtl/bomb_ctrl.sv
// Two-player bomb controller: arbitrates placement into a shared slot pool,
// enforces per-player quotas and publishes registered bomb/blast cell maps.
module bomb_ctrl
  import bomb_pkg::*;
#(
  parameter int NUM_SLOTS      = 4,
  parameter int MAX_PER_PLAYER = 2,
  parameter int FUSE_TICKS     = 120,
  parameter int BLAST_TICKS    = 30,
  parameter int RANGE          = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_tick,
  input  logic                  i_freeze,
  input  logic                  p1_place,
  input  logic                  p2_place,
  input  logic [7:0]            p1_cor,
  input  logic [7:0]            p2_cor,
  output logic                  o_p1_ack,
  output logic                  o_p2_ack,
  output logic [GRID_CELLS-1:0] o_bomb,
  output logic [GRID_CELLS-1:0] o_explode
);

  localparam int CNT_MAX = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  slot_state_t          w_state [NUM_SLOTS];
  cell_t                w_cell  [NUM_SLOTS];
  cell_t                w_load_cell [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] w_owner;
  logic [NUM_SLOTS-1:0] w_load;
  logic [NUM_SLOTS-1:0] w_load_owner;
  logic [NUM_SLOTS-1:0] w_chain;

  int   w_p1_live;
  int   w_p2_live;
  int   w_free_cnt;
  int   w_first_free;
  int   w_second_free;
  int   w_p2_slot;
  logic w_p1_busy;
  logic w_p2_busy;
  logic w_p1_ok;
  logic w_p2_ok;
  logic w_contend;
  logic w_grant1;
  logic w_grant2;

  logic [GRID_CELLS-1:0] w_bomb_map;
  logic [GRID_CELLS-1:0] w_explode_map;

  logic                  r_rr;
  logic                  r_p1_ack;
  logic                  r_p2_ack;
  logic [GRID_CELLS-1:0] r_bomb;
  logic [GRID_CELLS-1:0] r_explode;

  // Free-slot search, per-owner live counts and cell occupancy in one pass.
  always_comb begin
    w_p1_live     = 0;
    w_p2_live     = 0;
    w_free_cnt    = 0;
    w_first_free  = 0;
    w_second_free = 0;
    w_p1_busy     = 1'b0;
    w_p2_busy     = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_state[i] == S_IDLE) begin
        if (w_free_cnt == 0)      w_first_free  = i;
        else if (w_free_cnt == 1) w_second_free = i;
        w_free_cnt = w_free_cnt + 1;
      end else begin
        if (w_owner[i]) w_p2_live = w_p2_live + 1;
        else            w_p1_live = w_p1_live + 1;
        if (w_cell[i] == p1_cor) w_p1_busy = 1'b1;
        if (w_cell[i] == p2_cor) w_p2_busy = 1'b1;
      end
    end
  end

  assign w_p1_ok = p1_place && !i_freeze && (w_free_cnt >= 1) &&
                   (w_p1_live < MAX_PER_PLAYER) && !w_p1_busy;
  assign w_p2_ok = p2_place && !i_freeze && (w_free_cnt >= 1) &&
                   (w_p2_live < MAX_PER_PLAYER) && !w_p2_busy;

  // Both individually valid but only one can be placed: round-robin decides.
  assign w_contend = w_p1_ok && w_p2_ok && ((p1_cor == p2_cor) || (w_free_cnt < 2));
  assign w_grant1  = w_p1_ok && (!w_contend || !r_rr);
  assign w_grant2  = w_p2_ok && (!w_contend ||  r_rr);
  assign w_p2_slot = w_grant1 ? w_second_free : w_first_free;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      logic w_p1_hit;
      logic w_p2_hit;
      assign w_p1_hit         = w_grant1 && (w_first_free == gi);
      assign w_p2_hit         = w_grant2 && (w_p2_slot == gi);
      assign w_load[gi]       = w_p1_hit || w_p2_hit;
      assign w_load_cell[gi]  = w_p1_hit ? p1_cor : p2_cor;
      assign w_load_owner[gi] = !w_p1_hit;
      assign w_chain[gi]      = r_explode[w_cell[gi]];

      bomb_slot #(
        .FUSE_TICKS  (FUSE_TICKS),
        .BLAST_TICKS (BLAST_TICKS),
        .CNT_W       (CNT_W)
      ) u_slot (
        .clk      (clk),
        .reset    (reset),
        .i_tick   (i_tick),
        .i_freeze (i_freeze),
        .i_load   (w_load[gi]),
        .i_cell   (w_load_cell[gi]),
        .i_owner  (w_load_owner[gi]),
        .i_chain  (w_chain[gi]),
        .o_state  (w_state[gi]),
        .o_cell   (w_cell[gi]),
        .o_owner  (w_owner[gi])
      );
    end
  endgenerate

  always_comb begin
    w_bomb_map    = '0;
    w_explode_map = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (w_state[i] == S_FUSE)  w_bomb_map[w_cell[i]] = 1'b1;
      if (w_state[i] == S_BLAST) w_explode_map = w_explode_map | cross_mask(w_cell[i], RANGE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr      <= 1'b0;
      r_p1_ack  <= 1'b0;
      r_p2_ack  <= 1'b0;
      r_bomb    <= '0;
      r_explode <= '0;
    end else begin
      r_p1_ack  <= w_grant1;
      r_p2_ack  <= w_grant2;
      r_bomb    <= w_bomb_map;
      r_explode <= w_explode_map;
      if (w_contend) r_rr <= ~r_rr;
    end
  end

  assign o_p1_ack  = r_p1_ack;
  assign o_p2_ack  = r_p2_ack;
  assign o_bomb    = r_bomb;
  assign o_explode = r_explode;

endmodule

// File: tb/tb_bomb_ctrl.sv
// Directed bench for bomb_ctrl: placement acks via a scoreboard queue, fuse and
// blast timing, edge clipping, quota, arbitration, chain reaction, freeze, reset.
module tb_bomb_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_tick;
  logic         i_freeze;
  logic         p1_place;
  logic         p2_place;
  logic [7:0]   p1_cor;
  logic [7:0]   p2_cor;
  logic         o_p1_ack;
  logic         o_p2_ack;
  logic [255:0] o_bomb;
  logic [255:0] o_explode;

  int           total = 0;
  int           bad   = 0;
  logic [1:0]   ack_q[$];
  logic [255:0] e;
  logic [255:0] z;

  always #5 clk = ~clk;

  bomb_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .i_tick    (i_tick),
    .i_freeze  (i_freeze),
    .p1_place  (p1_place),
    .p2_place  (p2_place),
    .p1_cor    (p1_cor),
    .p2_cor    (p2_cor),
    .o_p1_ack  (o_p1_ack),
    .o_p2_ack  (o_p2_ack),
    .o_bomb    (o_bomb),
    .o_explode (o_explode)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    i_tick = 1'b1;
    repeat (n) step();
    i_tick = 1'b0;
  endtask

  task automatic chk_map(input string tag, input logic [255:0] act, input logic [255:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic act, input logic exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, act, exp);
    end
  endtask

  // Drive one request cycle; the expected ack pair is queued and checked next cycle.
  task automatic req(input logic a, input logic [7:0] ca, input logic b, input logic [7:0] cb,
                     input logic ea, input logic eb);
    logic [1:0] x;
    p1_place = a;
    p1_cor   = ca;
    p2_place = b;
    p2_cor   = cb;
    ack_q.push_back({ea, eb});
    step();
    p1_place = 1'b0;
    p2_place = 1'b0;
    x = ack_q.pop_front();
    chk_bit("p1_ack", o_p1_ack, x[1]);
    chk_bit("p2_ack", o_p2_ack, x[0]);
    $display("req p1=%0b@%h p2=%0b@%h -> ack p1=%0b p2=%0b (want %0b %0b)",
             a, ca, b, cb, o_p1_ack, o_p2_ack, x[1], x[0]);
  endtask

  // Expected cross built by distance test over the whole grid.
  function automatic logic [255:0] xcross(input int cx, input int cy, input int r);
    logic [255:0] m;
    int dx;
    int dy;
    m = '0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        dx = (x > cx) ? x - cx : cx - x;
        dy = (y > cy) ? y - cy : cy - y;
        if ((y == cy && dx <= r) || (x == cx && dy <= r)) m[8'(y * 16 + x)] = 1'b1;
      end
    end
    return m;
  endfunction

  initial begin
    z        = '0;
    reset    = 1'b1;
    i_tick   = 1'b0;
    i_freeze = 1'b0;
    p1_place = 1'b0;
    p2_place = 1'b0;
    p1_cor   = 8'h00;
    p2_cor   = 8'h00;
    step();
    step();
    chk_map("rst_bomb", o_bomb, z);
    chk_map("rst_explode", o_explode, z);
    chk_bit("rst_p1_ack", o_p1_ack, 1'b0);
    chk_bit("rst_p2_ack", o_p2_ack, 1'b0);
    reset = 1'b0;
    step();

    // Basic fuse/blast at 0x55, placed together with a tick.
    i_tick = 1'b1;
    req(1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0);
    i_tick = 1'b0;
    step();
    chk_bit("ack_pulse", o_p1_ack, 1'b0);
    e = '0;
    e[8'h55] = 1'b1;
    chk_map("bomb_55", o_bomb, e);
    ticks(119);
    step();
    chk_map("fuse_hold_explode", o_explode, z);
    chk_map("fuse_hold_bomb", o_bomb, e);
    ticks(1);
    step();
    e = '0;
    e[8'h55] = 1'b1; e[8'h35] = 1'b1; e[8'h45] = 1'b1; e[8'h65] = 1'b1; e[8'h75] = 1'b1;
    e[8'h53] = 1'b1; e[8'h54] = 1'b1; e[8'h56] = 1'b1; e[8'h57] = 1'b1;
    chk_map("blast_55", o_explode, e);
    chk_map("blast_55_bomb", o_bomb, z);
    ticks(29);
    step();
    chk_map("blast_55_hold", o_explode, e);
    ticks(1);
    step();
    chk_map("blast_55_clear", o_explode, z);

    // Corner clip at 0x00.
    req(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    ticks(120);
    step();
    e = '0;
    e[8'h00] = 1'b1; e[8'h01] = 1'b1; e[8'h02] = 1'b1; e[8'h10] = 1'b1; e[8'h20] = 1'b1;
    chk_map("blast_00_clip", o_explode, e);
    ticks(30);
    step();
    chk_map("blast_00_clear", o_explode, z);

    // Per-player quota.
    req(1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0);
    req(1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0);
    req(1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    e = '0;
    e[8'h11] = 1'b1; e[8'h22] = 1'b1;
    chk_map("quota_bombs", o_bomb, e);
    ticks(150);
    step();
    chk_map("quota_clear", o_explode, z);
    req(1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b0);
    ticks(150);
    step();
    chk_map("quota_new_clear", o_bomb, z);

    // Same-cell contention alternates winners.
    req(1'b1, 8'h77, 1'b1, 8'h77, 1'b1, 1'b0);
    ticks(150);
    step();
    req(1'b1, 8'h77, 1'b1, 8'h77, 1'b0, 1'b1);
    step();
    e = '0;
    e[8'h77] = 1'b1;
    chk_map("contend_bomb", o_bomb, e);
    ticks(150);
    step();

    // Chain reaction: B at 0x46 is caught by A's blast well before its own fuse ends.
    req(1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 1'b0);
    ticks(10);
    req(1'b0, 8'h00, 1'b1, 8'h46, 1'b0, 1'b1);
    ticks(110);
    step();
    e = '0;
    e[8'h46] = 1'b1;
    chk_map("chain_pre_bomb", o_bomb, e);
    chk_map("chain_pre_explode", o_explode, xcross(4, 4, 2));
    step();
    step();
    chk_map("chain_bomb_gone", o_bomb, z);
    chk_map("chain_explode", o_explode, xcross(4, 4, 2) | xcross(6, 4, 2));
    ticks(30);
    step();
    chk_map("chain_clear", o_explode, z);

    // Freeze holds counters and rejects placements; reset mid-blast clears everything.
    req(1'b1, 8'h99, 1'b0, 8'h00, 1'b1, 1'b0);
    ticks(30);
    i_freeze = 1'b1;
    ticks(50);
    req(1'b0, 8'h00, 1'b1, 8'hA0, 1'b0, 1'b0);
    i_freeze = 1'b0;
    ticks(89);
    step();
    e = '0;
    e[8'h99] = 1'b1;
    chk_map("freeze_bomb", o_bomb, e);
    chk_map("freeze_explode", o_explode, z);
    ticks(1);
    step();
    chk_map("freeze_blast", o_explode, xcross(9, 9, 2));
    ticks(10);
    reset    = 1'b1;
    i_tick   = 1'b1;
    p1_place = 1'b1;
    p1_cor   = 8'h33;
    step();
    reset    = 1'b0;
    i_tick   = 1'b0;
    p1_place = 1'b0;
    chk_map("reset_bomb", o_bomb, z);
    chk_map("reset_explode", o_explode, z);
    chk_bit("reset_p1_ack", o_p1_ack, 1'b0);
    step();
    chk_map("reset_explode_after", o_explode, z);

    // Both players accepted on distinct cells in one cycle.
    req(1'b1, 8'hA0, 1'b1, 8'hA5, 1'b1, 1'b1);
    step();
    e = '0;
    e[8'hA0] = 1'b1; e[8'hA5] = 1'b1;
    chk_map("dual_bombs", o_bomb, e);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bomb_ctrl.md
BOMB_CTRL -- requirements
Module: bomb_ctrl

Interface
REQ-001 Parameter: NUM_SLOTS, 4, bomb slots shared by both players.
REQ-002 Parameter: MAX_PER_PLAYER, 2, live-bomb limit per player.
REQ-003 Parameter: FUSE_TICKS, 120, ticks from placement to blast (>=1).
REQ-004 Parameter: BLAST_TICKS, 30, ticks a blast stays active (>=1).
REQ-005 Parameter: RANGE, 2, blast arm length in cells (1..3).
REQ-006 Port: clk  in  1  system clock; the only clock, with all state on its rising edge.
REQ-007 Port: reset  in  1  reset, synchronous and active-high.
REQ-008 Port: i_tick  in  1  one-cycle frame pulse (60 Hz).
REQ-009 Port: i_freeze  in  1  game halted; high whenever gameover_state != 0.
REQ-010 Port: p1_place / p2_place  in  1 each  single-cycle placement request.
REQ-011 Port: p1_cor / p2_cor  in  8 each  cell index; x = cor[3:0], y = cor[7:4], 16x16 grid.
REQ-012 Port: o_p1_ack / o_p2_ack  out  1 each  request accepted, one-cycle pulse.
REQ-013 Port: o_bomb  out  256  cells holding a bomb in FUSE.
REQ-014 Port: o_explode  out  256  cells currently in blast; feeds the gameover detector.

Function
REQ-015 Each slot SHALL hold state IDLE, FUSE or BLAST, plus an 8-bit cell, a 1-bit owner and a counter wide enough for max(FUSE_TICKS, BLAST_TICKS).
REQ-016 A request SHALL be accepted only if all hold: i_freeze low; a free slot exists; the requester owns < MAX_PER_PLAYER non-IDLE slots; no FUSE or BLAST slot holds the same cell.
REQ-017 An accepted request SHALL load the lowest-index IDLE slot: FUSE, counter = FUSE_TICKS.
REQ-018 If both players are accepted in one cycle, p1 SHALL take the lowest free slot and p2 the next one.
REQ-019 If both players request and only one can be served (one free slot, or the same cell), the round-robin pointer SHALL pick the winner, and the loser SHALL be dropped with no ack.
REQ-020 The round-robin pointer SHALL reset to favour p1 and SHALL toggle after every contended cycle.
REQ-021 The ack SHALL assert in the cycle after the request, for exactly one cycle; rejected requests SHALL produce no ack and SHALL not be retried.
REQ-022 FUSE: on i_tick with counter == 1, the slot SHALL go to BLAST with counter = BLAST_TICKS; otherwise i_tick SHALL decrement the counter.
REQ-023 Chain reaction: a FUSE slot whose cell is set in o_explode SHALL go to BLAST on the next edge, independent of i_tick.
REQ-024 BLAST: on i_tick with counter == 1, the slot SHALL go to IDLE and free its owner's quota.
REQ-025 The blast cross SHALL cover the bomb cell plus up to RANGE cells in each of the four directions, clipped at grid edges with no wrap-around.
REQ-026 o_explode SHALL be the registered OR of all BLAST crosses, updating one cycle after a slot state change; o_bomb SHALL be registered in the same way from FUSE slots.
REQ-027 While i_freeze is high, ticks SHALL be ignored, counters and states SHALL hold, chain reactions SHALL still propagate and placements SHALL be rejected.
REQ-028 i_tick and a placement in the same cycle: the new slot SHALL NOT be decremented in that cycle.

Reset
REQ-029 On reset high at a clock edge, all slots SHALL go to IDLE with counters 0, o_bomb and o_explode SHALL be 0, acks SHALL be 0 and the round-robin pointer SHALL favour p1.
REQ-030 Reset SHALL override any in-flight request, tick or chain reaction in the same cycle.

Structure
REQ-031 Package bomb_pkg SHALL hold the slot-state enum (S_IDLE, S_FUSE, S_BLAST), GRID_W = 16, the cell/coordinate typedef, and the cross-mask function.
REQ-032 Sub-module bomb_slot SHALL implement one slot (state, counter, cell, owner), instantiated NUM_SLOTS times.
REQ-033 Arbitration, quota counting and map generation SHALL reside in bomb_ctrl.

Verification
REQ-034 p1_place at cor 8'h55, then 120 ticks -> o_p1_ack next cycle; o_bomb[0x55] set; after tick 120, o_explode sets 0x55, 0x35, 0x45, 0x65, 0x75, 0x53, 0x54, 0x56 and 0x57; the map clears after 30 more ticks.
REQ-035 Bomb at 8'h00 with RANGE 2 -> o_explode is exactly cells 0x00, 0x01, 0x02, 0x10 and 0x20 (edge clip, no wrap).
REQ-036 p1 places 3 bombs at distinct cells -> third request gets no ack; after the first blast clears, a new p1 request is acked.
REQ-037 Both players request cell 0x77 in the same cycle twice (after clearing) -> p1 acked first time, p2 second time; never both.
REQ-038 Bomb A at 0x44 fused, bomb B at 0x46 placed 10 ticks later -> B enters BLAST one cycle after A's blast covers 0x46, not after its own fuse.
REQ-039 Assert i_freeze mid-fuse for 50 ticks, then pulse reset mid-blast -> counters hold during freeze; next cycle after reset all outputs are 0.
